// File: rtl/fmul_div_unit.sv
// fmul_div_unit: iterative binary32 multiply (shift-add) / divide (restoring) returning unrounded sign/exp/frac/GRS.
// Latency 26 mul / 29 div cycles + 1 per normalise shift, 2 for specials; result held while en high; FMULDIV_CHECK_EN mirrors the product/quotient.
module fmul_div_unit #(
    parameter int OPERAND_WIDTH     = 32,
    parameter int EXPONENT_WIDTH    = 8,
    parameter int FRACTION_WIDTH    = 23,
    parameter int SIGNIFICAND_WIDTH = FRACTION_WIDTH + 1,
    parameter int PRCSN_WIDTH       = SIGNIFICAND_WIDTH + 2,
    parameter logic [EXPONENT_WIDTH-1:0] BIASING_CONSTANT = 8'd127
) (
    input  logic                           fpu_clk,
    input  logic                           fpu_rst,
    input  logic                           fmuldiv_en_i,
    input  logic                           fmuldiv_sel_i,
    input  logic                           fmuldiv_sign1_i,
    input  logic                           fmuldiv_sign2_i,
    input  logic [EXPONENT_WIDTH-1:0]      fmuldiv_exp1_i,
    input  logic [EXPONENT_WIDTH-1:0]      fmuldiv_exp2_i,
    input  logic [SIGNIFICAND_WIDTH-1:0]   fmuldiv_scfnd1_i,
    input  logic [SIGNIFICAND_WIDTH-1:0]   fmuldiv_scfnd2_i,
    output logic                           fmuldiv_sign_o,
    output logic [EXPONENT_WIDTH-1:0]      fmuldiv_exp_o,
    output logic [FRACTION_WIDTH-1:0]      fmuldiv_frac_o,
    output logic [2:0]                     fmuldiv_grs_bit_o,
    output logic                           fmuldiv_ready_o,
    output logic                           fmuldiv_exp_ovf_o,
    output logic [2*SIGNIFICAND_WIDTH-1:0] fmuldiv_check
);

    localparam int SW = SIGNIFICAND_WIDTH;
    localparam int NW = 2 * SIGNIFICAND_WIDTH;
    localparam int QW = PRCSN_WIDTH + 1;
    localparam int XW = EXPONENT_WIDTH + 2;
    localparam int CW = $clog2(QW);
    localparam logic signed [XW-1:0] ONE_X    = {{(XW-1){1'b0}}, 1'b1};
    localparam logic signed [XW-1:0] BIAS_X   = {2'b00, BIASING_CONSTANT};
    localparam logic signed [XW-1:0] EXP_ALL1 = {2'b00, {EXPONENT_WIDTH{1'b1}}};
    localparam logic [FRACTION_WIDTH-1:0] QNAN_FRAC = {1'b1, {(FRACTION_WIDTH-1){1'b0}}};

    generate
        if (OPERAND_WIDTH != 1 + EXPONENT_WIDTH + FRACTION_WIDTH) begin : g_bad_layout
            $error("fmul_div_unit: operand field widths do not add up");
        end
    endgenerate

    typedef enum logic [2:0] {S_IDLE, S_PRENORM, S_CALC, S_POSTNORM, S_DONE} state_t;

    state_t                     state_q;
    logic                       sel_q, sign_q, sticky_q;
    logic signed [XW-1:0]       e1_q, e2_q, exp_q;
    logic [SW-1:0]              m1_q, m2_q;
    logic [NW-1:0]              rem_q, acc_q, norm_q;
    logic [CW-1:0]              cnt_q;
    logic                       res_sign_q, ready_q, ovf_q;
    logic [EXPONENT_WIDTH-1:0]  res_exp_q;
    logic [FRACTION_WIDTH-1:0]  res_frac_q;
    logic [2:0]                 res_grs_q;

    logic                       zero1, zero2, special, needs_pn;
    logic signed [XW-1:0]       e1_in, e2_in;
    logic [SW-1:0]              m1_pn_d, m2_pn_d;
    logic signed [XW-1:0]       e1_pn_d, e2_pn_d;
    logic                       pn_done_d;
    logic [SW+1:0]              div_rem, div_diff;
    logic                       div_ge;
    logic [NW-1:0]              acc_d, rem_d, norm_d;
    logic signed [XW-1:0]       exp_d;
    logic                       sticky_d, calc_last_d;

    assign zero1    = ~|fmuldiv_scfnd1_i;
    assign zero2    = ~|fmuldiv_scfnd2_i;
    assign special  = zero1 | zero2;
    assign needs_pn = ~fmuldiv_scfnd1_i[SW-1] | ~fmuldiv_scfnd2_i[SW-1];
    assign e1_in    = (fmuldiv_exp1_i == '0) ? ONE_X : $signed({2'b00, fmuldiv_exp1_i});
    assign e2_in    = (fmuldiv_exp2_i == '0) ? ONE_X : $signed({2'b00, fmuldiv_exp2_i});

    // One normalising shift per cycle, dividend/multiplicand first; lookahead ends PRENORM on the last shift.
    always_comb begin
        m1_pn_d = m1_q;
        m2_pn_d = m2_q;
        e1_pn_d = e1_q;
        e2_pn_d = e2_q;
        if (!m1_q[SW-1]) begin
            m1_pn_d = m1_q << 1;
            e1_pn_d = e1_q - ONE_X;
        end else if (!m2_q[SW-1]) begin
            m2_pn_d = m2_q << 1;
            e2_pn_d = e2_q - ONE_X;
        end
        pn_done_d = m1_pn_d[SW-1] & m2_pn_d[SW-1];
    end

    assign div_rem  = rem_q[SW+1:0];
    assign div_ge   = div_rem >= {2'b00, m2_q};
    assign div_diff = div_ge ? (div_rem - {2'b00, m2_q}) : div_rem;

    always_comb begin
        acc_d       = '0;
        rem_d       = '0;
        norm_d      = '0;
        exp_d       = '0;
        sticky_d    = 1'b0;
        calc_last_d = 1'b0;
        if (sel_q) begin
            acc_d       = {acc_q[NW-2:0], div_ge};
            rem_d       = {{(NW-SW-1){1'b0}}, div_diff[SW-1:0], 1'b0};
            calc_last_d = (cnt_q == CW'(QW-1));
            sticky_d    = |div_diff;
            if (acc_d[QW-1]) begin
                norm_d = {acc_d[QW-1:0], {(NW-QW){1'b0}}};
                exp_d  = e1_q - e2_q + BIAS_X;
            end else begin
                norm_d = {acc_d[QW-2:0], {(NW-QW+1){1'b0}}};
                exp_d  = e1_q - e2_q + BIAS_X - ONE_X;
            end
        end else begin
            acc_d       = acc_q + (m2_q[cnt_q] ? rem_q : '0);
            rem_d       = rem_q << 1;
            calc_last_d = (cnt_q == CW'(SW-1));
            if (acc_d[NW-1]) begin
                norm_d = acc_d;
                exp_d  = e1_q + e2_q - BIAS_X + ONE_X;
            end else begin
                norm_d = acc_d << 1;
                exp_d  = e1_q + e2_q - BIAS_X;
            end
        end
    end

    always_ff @(posedge fpu_clk) begin
        if (fpu_rst) begin
            state_q    <= S_IDLE;
            sel_q      <= 1'b0;
            sign_q     <= 1'b0;
            sticky_q   <= 1'b0;
            e1_q       <= '0;
            e2_q       <= '0;
            exp_q      <= '0;
            m1_q       <= '0;
            m2_q       <= '0;
            rem_q      <= '0;
            acc_q      <= '0;
            norm_q     <= '0;
            cnt_q      <= '0;
            res_sign_q <= 1'b0;
            res_exp_q  <= '0;
            res_frac_q <= '0;
            res_grs_q  <= '0;
            ready_q    <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ready_q <= 1'b0;
                    if (fmuldiv_en_i) begin
                        sel_q    <= fmuldiv_sel_i;
                        sign_q   <= fmuldiv_sign1_i ^ fmuldiv_sign2_i;
                        m1_q     <= fmuldiv_scfnd1_i;
                        m2_q     <= fmuldiv_scfnd2_i;
                        e1_q     <= e1_in;
                        e2_q     <= e2_in;
                        rem_q    <= {{(NW-SW){1'b0}}, fmuldiv_scfnd1_i};
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        sticky_q <= 1'b0;
                        if (special) begin
                            state_q    <= S_DONE;
                            res_sign_q <= fmuldiv_sign1_i ^ fmuldiv_sign2_i;
                            res_grs_q  <= '0;
                            if (fmuldiv_sel_i && zero2) begin
                                res_exp_q  <= '1;
                                res_frac_q <= zero1 ? QNAN_FRAC : '0;
                                ovf_q      <= 1'b1;
                            end else begin
                                res_exp_q  <= '0;
                                res_frac_q <= '0;
                                ovf_q      <= 1'b0;
                            end
                        end else begin
                            state_q <= needs_pn ? S_PRENORM : S_CALC;
                        end
                    end
                end
                S_PRENORM: begin
                    if (!fmuldiv_en_i) begin
                        state_q <= S_IDLE;
                    end else begin
                        m1_q  <= m1_pn_d;
                        m2_q  <= m2_pn_d;
                        e1_q  <= e1_pn_d;
                        e2_q  <= e2_pn_d;
                        rem_q <= {{(NW-SW){1'b0}}, m1_pn_d};
                        if (pn_done_d) state_q <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (!fmuldiv_en_i) begin
                        state_q <= S_IDLE;
                    end else begin
                        acc_q <= acc_d;
                        rem_q <= rem_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (calc_last_d) begin
                            norm_q   <= norm_d;
                            exp_q    <= exp_d;
                            sticky_q <= sticky_d;
                            state_q  <= S_POSTNORM;
                        end
                    end
                end
                S_POSTNORM: begin
                    if (!fmuldiv_en_i) begin
                        state_q <= S_IDLE;
                    end else if (exp_q < ONE_X) begin
                        // Denormalise towards E=1, folding lost bits into sticky.
                        norm_q   <= norm_q >> 1;
                        sticky_q <= sticky_q | norm_q[0];
                        exp_q    <= exp_q + ONE_X;
                    end else begin
                        res_sign_q <= sign_q;
                        ready_q    <= 1'b1;
                        state_q    <= S_DONE;
                        if (exp_q >= EXP_ALL1) begin
                            res_exp_q  <= '1;
                            res_frac_q <= '0;
                            res_grs_q  <= '0;
                            ovf_q      <= 1'b1;
                        end else begin
                            res_exp_q  <= norm_q[NW-1] ? exp_q[EXPONENT_WIDTH-1:0] : '0;
                            res_frac_q <= norm_q[NW-2 -: FRACTION_WIDTH];
                            res_grs_q  <= {norm_q[NW-2-FRACTION_WIDTH], norm_q[NW-3-FRACTION_WIDTH],
                                           (|norm_q[NW-4-FRACTION_WIDTH:0]) | sticky_q};
                            ovf_q      <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    if (fmuldiv_en_i) begin
                        ready_q <= 1'b1;
                    end else begin
                        ready_q <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign fmuldiv_sign_o    = res_sign_q;
    assign fmuldiv_exp_o     = res_exp_q;
    assign fmuldiv_frac_o    = res_frac_q;
    assign fmuldiv_grs_bit_o = res_grs_q;
    assign fmuldiv_ready_o   = ready_q;
    assign fmuldiv_exp_ovf_o = ovf_q;

`ifdef FMULDIV_CHECK_EN
    assign fmuldiv_check = acc_q;
`else
    assign fmuldiv_check = '0;
`endif

endmodule

// File: tb/tb_fmul_div_unit.sv
// Directed bench for fmul_div_unit: results, latencies, handshake, abort and reset.
module tb_fmul_div_unit;

    logic        fpu_clk = 1'b0;
    logic        fpu_rst;
    logic        fmuldiv_en_i, fmuldiv_sel_i;
    logic        fmuldiv_sign1_i, fmuldiv_sign2_i;
    logic [7:0]  fmuldiv_exp1_i, fmuldiv_exp2_i;
    logic [23:0] fmuldiv_scfnd1_i, fmuldiv_scfnd2_i;
    logic        fmuldiv_sign_o;
    logic [7:0]  fmuldiv_exp_o;
    logic [22:0] fmuldiv_frac_o;
    logic [2:0]  fmuldiv_grs_bit_o;
    logic        fmuldiv_ready_o, fmuldiv_exp_ovf_o;
    logic [47:0] fmuldiv_check;
    logic [35:0] res;

    int checks   = 0;
    int failures = 0;

    fmul_div_unit dut (
        .fpu_clk           (fpu_clk),
        .fpu_rst           (fpu_rst),
        .fmuldiv_en_i      (fmuldiv_en_i),
        .fmuldiv_sel_i     (fmuldiv_sel_i),
        .fmuldiv_sign1_i   (fmuldiv_sign1_i),
        .fmuldiv_sign2_i   (fmuldiv_sign2_i),
        .fmuldiv_exp1_i    (fmuldiv_exp1_i),
        .fmuldiv_exp2_i    (fmuldiv_exp2_i),
        .fmuldiv_scfnd1_i  (fmuldiv_scfnd1_i),
        .fmuldiv_scfnd2_i  (fmuldiv_scfnd2_i),
        .fmuldiv_sign_o    (fmuldiv_sign_o),
        .fmuldiv_exp_o     (fmuldiv_exp_o),
        .fmuldiv_frac_o    (fmuldiv_frac_o),
        .fmuldiv_grs_bit_o (fmuldiv_grs_bit_o),
        .fmuldiv_ready_o   (fmuldiv_ready_o),
        .fmuldiv_exp_ovf_o (fmuldiv_exp_ovf_o),
        .fmuldiv_check     (fmuldiv_check)
    );

    always #5 fpu_clk = ~fpu_clk;

    // {sign, exp, frac, grs, ovf}
    assign res = {fmuldiv_sign_o, fmuldiv_exp_o, fmuldiv_frac_o, fmuldiv_grs_bit_o, fmuldiv_exp_ovf_o};

    task automatic drive_op(input logic sel, input logic [31:0] a, input logic [31:0] b);
        fmuldiv_sel_i    = sel;
        fmuldiv_sign1_i  = a[31];
        fmuldiv_exp1_i   = a[30:23];
        fmuldiv_scfnd1_i = {|a[30:23], a[22:0]};
        fmuldiv_sign2_i  = b[31];
        fmuldiv_exp2_i   = b[30:23];
        fmuldiv_scfnd2_i = {|b[30:23], b[22:0]};
        fmuldiv_en_i     = 1'b1;
    endtask

    // Raises en and counts rising edges until ready (bounded); en stays high.
    task automatic do_op(input logic sel, input logic [31:0] a, input logic [31:0] b, output int cyc);
        @(negedge fpu_clk);
        drive_op(sel, a, b);
        cyc = 0;
        do begin
            @(posedge fpu_clk);
            #1;
            cyc++;
        end while (!fmuldiv_ready_o && cyc < 400);
    endtask

    task automatic finish_op;
        @(negedge fpu_clk);
        fmuldiv_en_i = 1'b0;
        @(posedge fpu_clk);
        #1;
    endtask

    task automatic test_reset;
        fpu_rst = 1'b1;
        drive_op(1'b0, 32'h0, 32'h0);
        fmuldiv_en_i = 1'b0;
        repeat (3) @(posedge fpu_clk);
        #1;
        checks++;
        if (res !== 36'h0 || fmuldiv_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got res=%h ready=%b, expected res=0 ready=0", res, fmuldiv_ready_o);
        end
        checks++;
        if (fmuldiv_check !== 48'h0) begin
            failures++;
            $display("FAIL reset_check: got %h, expected 0", fmuldiv_check);
        end
        @(negedge fpu_clk);
        fpu_rst = 1'b0;
    endtask

    task automatic test_mul_normal;
        int cyc;
        logic [35:0] want;
        do_op(1'b0, 32'h3FC00000, 32'h40000000, cyc);
        want = {1'b0, 8'h80, 23'h400000, 3'b000, 1'b0};
        checks++;
        if (cyc !== 26) begin failures++; $display("FAIL mul_3_latency: got %0d, expected 26", cyc); end
        checks++;
        if (res !== want) begin failures++; $display("FAIL mul_3_result: got %h, expected %h", res, want); end
        finish_op;
        do_op(1'b0, 32'h3F800001, 32'h3F800001, cyc);
        want = {1'b0, 8'h7F, 23'h000002, 3'b001, 1'b0};
        checks++;
        if (cyc !== 26) begin failures++; $display("FAIL mul_sticky_latency: got %0d, expected 26", cyc); end
        checks++;
        if (res !== want) begin failures++; $display("FAIL mul_sticky_result: got %h, expected %h", res, want); end
        finish_op;
    endtask

    task automatic test_div_normal;
        int cyc;
        logic [35:0] want;
        do_op(1'b1, 32'h3F800000, 32'h40400000, cyc);
        want = {1'b0, 8'h7D, 23'h2AAAAA, 3'b101, 1'b0};
        checks++;
        if (cyc !== 29) begin failures++; $display("FAIL div_third_latency: got %0d, expected 29", cyc); end
        checks++;
        if (res !== want) begin failures++; $display("FAIL div_third_result: got %h, expected %h", res, want); end
        finish_op;
    endtask

    task automatic test_special;
        int cyc;
        logic [35:0] want;
        do_op(1'b0, 32'h80000000, 32'hC2009235, cyc);
        want = {1'b0, 8'h00, 23'h0, 3'b000, 1'b0};
        checks++;
        if (cyc !== 2) begin failures++; $display("FAIL mul_zero_latency: got %0d, expected 2", cyc); end
        checks++;
        if (res !== want) begin failures++; $display("FAIL mul_zero_result: got %h, expected %h", res, want); end
        finish_op;
        do_op(1'b1, 32'hBF800000, 32'h00000000, cyc);
        want = {1'b1, 8'hFF, 23'h0, 3'b000, 1'b1};
        checks++;
        if (cyc !== 2) begin failures++; $display("FAIL div_by_zero_latency: got %0d, expected 2", cyc); end
        checks++;
        if (res !== want) begin failures++; $display("FAIL div_by_zero_result: got %h, expected %h", res, want); end
        finish_op;
        do_op(1'b1, 32'h80000000, 32'h00000000, cyc);
        want = {1'b1, 8'hFF, 23'h400000, 3'b000, 1'b1};
        checks++;
        if (res !== want || cyc !== 2) begin
            failures++;
            $display("FAIL div_zero_by_zero: got %h after %0d cycles, expected %h after 2", res, cyc, want);
        end
        finish_op;
    endtask

    task automatic test_overflow;
        int cyc;
        logic [35:0] want;
        do_op(1'b0, 32'h7F000000, 32'h7F000000, cyc);
        want = {1'b0, 8'hFF, 23'h0, 3'b000, 1'b1};
        checks++;
        if (res !== want || cyc !== 26) begin
            failures++;
            $display("FAIL mul_overflow: got %h after %0d cycles, expected %h after 26", res, cyc, want);
        end
        finish_op;
    endtask

    task automatic test_subnormal;
        int cyc;
        logic [35:0] want;
        do_op(1'b0, 32'h00400000, 32'h40000000, cyc);
        want = {1'b0, 8'h01, 23'h0, 3'b000, 1'b0};
        checks++;
        if (cyc !== 27) begin failures++; $display("FAIL sub_prenorm_latency: got %0d, expected 27", cyc); end
        checks++;
        if (res !== want) begin failures++; $display("FAIL sub_prenorm_result: got %h, expected %h", res, want); end
        finish_op;
        do_op(1'b0, 32'h00000001, 32'h3F000000, cyc);
        want = {1'b0, 8'h00, 23'h0, 3'b100, 1'b0};
        checks++;
        if (cyc !== 73) begin failures++; $display("FAIL sub_postnorm_latency: got %0d, expected 73", cyc); end
        checks++;
        if (res !== want) begin failures++; $display("FAIL sub_postnorm_result: got %h, expected %h", res, want); end
        finish_op;
    endtask

    task automatic test_handshake;
        int cyc;
        logic [35:0] want;
        do_op(1'b0, 32'h3FC00000, 32'h40000000, cyc);
        want = {1'b0, 8'h80, 23'h400000, 3'b000, 1'b0};
        @(negedge fpu_clk);
        drive_op(1'b1, 32'h40400000, 32'h3F800000);
        for (int i = 0; i < 3; i++) begin
            @(posedge fpu_clk);
            #1;
            checks++;
            if (fmuldiv_ready_o !== 1'b1 || res !== want) begin
                failures++;
                $display("FAIL hold_cycle%0d: got ready=%b res=%h, expected ready=1 res=%h", i, fmuldiv_ready_o, res, want);
            end
        end
        finish_op;
        checks++;
        if (fmuldiv_ready_o !== 1'b0) begin failures++; $display("FAIL release_ready: got %b, expected 0", fmuldiv_ready_o); end
        checks++;
        if (res !== want) begin failures++; $display("FAIL release_hold: got %h, expected %h", res, want); end
    endtask

    task automatic test_abort;
        int cyc;
        logic [35:0] want;
        @(negedge fpu_clk);
        drive_op(1'b0, 32'h3F800001, 32'h3F800001);
        repeat (6) @(posedge fpu_clk);
        @(negedge fpu_clk);
        fmuldiv_en_i = 1'b0;
        repeat (30) @(posedge fpu_clk);
        #1;
        want = {1'b0, 8'h80, 23'h400000, 3'b000, 1'b0};
        checks++;
        if (fmuldiv_ready_o !== 1'b0 || res !== want) begin
            failures++;
            $display("FAIL abort_no_result: got ready=%b res=%h, expected ready=0 res=%h", fmuldiv_ready_o, res, want);
        end
        do_op(1'b0, 32'h3F800001, 32'h3F800001, cyc);
        want = {1'b0, 8'h7F, 23'h000002, 3'b001, 1'b0};
        checks++;
        if (res !== want || cyc !== 26) begin
            failures++;
            $display("FAIL abort_restart: got %h after %0d cycles, expected %h after 26", res, cyc, want);
        end
        finish_op;
    endtask

    task automatic test_reset_midcalc;
        int cyc;
        logic [35:0] want;
        @(negedge fpu_clk);
        drive_op(1'b1, 32'h3F800000, 32'h40400000);
        repeat (12) @(posedge fpu_clk);
        @(negedge fpu_clk);
        fpu_rst      = 1'b1;
        fmuldiv_en_i = 1'b0;
        @(posedge fpu_clk);
        #1;
        checks++;
        if (fmuldiv_ready_o !== 1'b0 || res !== 36'h0) begin
            failures++;
            $display("FAIL midcalc_reset: got ready=%b res=%h, expected ready=0 res=0", fmuldiv_ready_o, res);
        end
        @(negedge fpu_clk);
        fpu_rst = 1'b0;
        repeat (30) @(posedge fpu_clk);
        #1;
        checks++;
        if (fmuldiv_ready_o !== 1'b0) begin failures++; $display("FAIL midcalc_no_resume: got ready=%b, expected 0", fmuldiv_ready_o); end
        do_op(1'b1, 32'hC0C00000, 32'h40000000, cyc);
        want = {1'b1, 8'h80, 23'h400000, 3'b000, 1'b0};
        checks++;
        if (cyc !== 29) begin failures++; $display("FAIL midcalc_restart_latency: got %0d, expected 29", cyc); end
        checks++;
        if (res !== want) begin failures++; $display("FAIL midcalc_restart_result: got %h, expected %h", res, want); end
        finish_op;
    endtask

    task automatic test_back_to_back;
        int cyc;
        logic [35:0] want;
        do_op(1'b1, 32'h3F800000, 32'h40400000, cyc);
        want = {1'b0, 8'h7D, 23'h2AAAAA, 3'b101, 1'b0};
        checks++;
        if (res !== want || cyc !== 29) begin
            failures++;
            $display("FAIL b2b_first: got %h after %0d cycles, expected %h after 29", res, cyc, want);
        end
        finish_op;
        do_op(1'b0, 32'h40400000, 32'h40400000, cyc);
        want = {1'b0, 8'h82, 23'h100000, 3'b000, 1'b0};
        checks++;
        if (cyc !== 26) begin failures++; $display("FAIL b2b_second_latency: got %0d, expected 26", cyc); end
        checks++;
        if (res !== want) begin failures++; $display("FAIL b2b_second_result: got %h, expected %h", res, want); end
        finish_op;
    endtask

    initial begin
        test_reset();
        test_mul_normal();
        test_div_normal();
        test_special();
        test_overflow();
        test_subnormal();
        test_handshake();
        test_abort();
        test_reset_midcalc();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fmul_div_unit.md
Name: fmul_div_unit

Overview:
- Iterative single-precision (IEEE-754 binary32) multiply/divide datapath inside the FPU.
- Takes unpacked operands (sign, biased exponent, significand with explicit J bit) and returns an unrounded result: sign, exponent, 23-bit fraction and guard/round/sticky (GRS) bits.
- A downstream rounding/packing stage consumes the result.
- Uses an enable/ready handshake, with multi-cycle shift-add multiplication and restoring division.

Parameters:
- OPERAND_WIDTH, 32, packed operand width (informational)
- EXPONENT_WIDTH, 8, biased exponent width
- FRACTION_WIDTH, 23, stored fraction width
- SIGNIFICAND_WIDTH, FRACTION_WIDTH+1, significand width including J bit
- PRCSN_WIDTH, SIGNIFICAND_WIDTH+2, internal quotient precision (significand + guard + round)
- BIASING_CONSTANT, 8'd127, exponent bias

Ports:
- fpu_clk  in  1  clock, rising edge
- fpu_rst  in  1  synchronous active-high reset
- fmuldiv_en_i  in  1  operation request; held high until ready seen
- fmuldiv_sel_i  in  1  0 = multiply, 1 = divide (op1/op2)
- fmuldiv_sign1_i / fmuldiv_sign2_i  in  1  operand signs
- fmuldiv_exp1_i / fmuldiv_exp2_i  in  EXPONENT_WIDTH  biased exponents; 0 = zero/subnormal
- fmuldiv_scfnd1_i / fmuldiv_scfnd2_i  in  SIGNIFICAND_WIDTH  {J bit, fraction}; J = |exp
- fmuldiv_sign_o  out  1  result sign
- fmuldiv_exp_o  out  EXPONENT_WIDTH  result biased exponent
- fmuldiv_frac_o  out  FRACTION_WIDTH  result fraction, J bit dropped
- fmuldiv_grs_bit_o  out  3  {guard, round, sticky}
- fmuldiv_ready_o  out  1  result valid
- fmuldiv_exp_ovf_o  out  1  exponent overflow / infinity result
- fmuldiv_check  out  2*SIGNIFICAND_WIDTH  debug: raw product or quotient register

Behaviour:
- Reset (fpu_rst=1 at a clock edge): all outputs 0, FSM goes to IDLE. Reset aborts any operation mid-flight with no partial result.
- FSM states: IDLE → PRENORM → CALC → POSTNORM → DONE → IDLE.
- IDLE: on en=1, latch all operands and sel, then go to PRENORM. Later input changes are ignored until the next start.
- Special-case detection in IDLE: if any operand significand is 0, or divisor is 0, go straight to DONE with the special result.
- PRENORM: left-shift a subnormal significand one bit per cycle until the J bit is 1. The effective exponent starts at 1 for exp=0 and is decremented once per shift.
- CALC, multiply: 24-cycle shift-add gives a 48-bit product P.
  - Exponent: E = e1 + e2 − BIAS, computed signed with 2 extra bits.
  - If P[47]=1, E+1 and take bits from 47; otherwise take them from 46.
- CALC, divide: restoring division, one quotient bit per cycle, PRCSN_WIDTH+1 = 27 bits.
  - Exponent: E = e1 − e2 + BIAS.
  - If the quotient MSB is 0, shift left 1 and E−1.
  - Sticky includes a nonzero remainder.
- POSTNORM:
  - If E ≤ 0: shift right one bit per cycle (OR-ing lost bits into sticky) until E = 1, then output exp = 0 (subnormal).
  - If E ≥ 255: exp_ovf = 1, exp = 8'hFF, frac = 0, grs = 0.
- Result fields:
  - frac = 23 bits below the leading one.
  - guard and round = next two bits.
  - sticky = OR of all remaining bits (and remainder).
  - sign = s1 ^ s2 always, including special results.
- Special results:
  - Zero operand (mul), or zero dividend with nonzero divisor: exp 0, frac 0, grs 0, ovf 0.
  - x/0 with x ≠ 0: exp FF, frac 0, ovf 1.
  - 0/0: exp FF, frac 23'h400000, ovf 1.
  - exp = FF inputs are not special-cased; upstream handles Inf/NaN.
- DONE:
  - ready = 1 and outputs held stable while en = 1.
  - When en is sampled 0, next cycle ready = 0 and the FSM returns to IDLE. Result outputs keep their last value.
- en dropping before DONE aborts the operation and returns to IDLE with ready = 0.
- Latency:
  - Normal multiply: 1 + 24 + 1 = 26 cycles from en to ready; divide 29.
  - Add 1 cycle per PRENORM or POSTNORM shift.
  - Special cases: ready 2 cycles after en.

Optional Feature:
- Macro FMULDIV_CHECK_EN.
- Defined: fmuldiv_check mirrors the internal product/quotient register every cycle (quotient zero-extended).
- Undefined: fmuldiv_check tied to 0 and the mirror logic is removed.

Test Plan:
- Multiply 0x3FC00000 × 0x40000000 → sign 0, exp 0x80, frac 0x400000, grs 000, ovf 0, ready after 26 cycles.
- Divide 0x3F800000 / 0x40400000 → sign 0, exp 0x7D, frac 0x2AAAAA, grs 101.
- Multiply 0x80000000 × 0xC2009235 → sign 0, exp 0, frac 0, grs 000; ready 2 cycles after en.
- Multiply 0x7F000000 × 0x7F000000 → ovf 1, exp 0xFF, frac 0. Divide 0xBF800000 / 0x00000000 → sign 1, exp 0xFF, ovf 1.
- Multiply subnormal 0x00400000 × 0x40000000 → exp 0x01, frac 0, grs 000; 0x00000001 × 0x3F000000 → exp 0, frac 0, grs 100.
- Handshake: hold en 3 cycles after ready → outputs stable; drop en → ready 0 next cycle. Assert reset mid-CALC → ready 0, restart works.
